// File: rtl/game_2048_status_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : game_2048_status_scan_if
//  Purpose  : Request/status bundle between the 2048 control layer (master)
//             and the board status scanner (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface game_2048_status_scan_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int TILE_W = 4
);
    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N + 1);

    logic [N*TILE_W-1:0] board_state;
    logic                start;
    logic                clear;
    logic                busy;
    logic                done;
    logic                game_win;
    logic                game_lose;
    logic                can_move;
    logic [CW-1:0]       empty_count;
    logic [TILE_W-1:0]   max_tile;

    // Control layer: drives the board and requests, observes status.
    modport master (
        output board_state, start, clear,
        input  busy, done, game_win, game_lose, can_move, empty_count, max_tile
    );

    // Scanner: consumes the board and requests, produces status.
    modport slave (
        input  board_state, start, clear,
        output busy, done, game_win, game_lose, can_move, empty_count, max_tile
    );
endinterface
`default_nettype wire

// File: rtl/game_2048_status_scan.sv
`default_nettype none
// ============================================================================
//  Module   : game_2048_status_scan
//  Purpose  : Sequential win/lose evaluator for the 2048 core. On start the
//             board is snapshotted and walked one tile per clock; empty count,
//             max exponent, win and merge availability are accumulated and
//             published with a one-cycle done pulse. Win/lose flags are sticky
//             until reset_n or clear.
//  Config   : GAME_STATUS_CONTINUE_EN - play-past-win mode; game_lose is
//             evaluated on every scan even when game_win is set.
//  Revision : 1.0  initial release
// ============================================================================
module game_2048_status_scan #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int TILE_W  = 4,
    parameter int WIN_EXP = 11
) (
    input  wire logic clk,
    input  wire logic reset_n,
    game_2048_status_scan_if.slave bus
);
    localparam int N   = ROWS * COLS;
    localparam int CW  = $clog2(N + 1);
    localparam int IW  = $clog2(N);
    localparam int RW  = $clog2(ROWS);
    localparam int CLW = $clog2(COLS);

    localparam logic [RW-1:0]  LAST_R   = RW'(ROWS - 1);
    localparam logic [CLW-1:0] LAST_C   = CLW'(COLS - 1);
    localparam logic [RW-1:0]  ONE_R    = RW'(1);
    localparam logic [CLW-1:0] ONE_C    = CLW'(1);
    localparam logic [IW-1:0]  ONE_IDX  = IW'(1);
    localparam logic [IW-1:0]  COLS_IDX = IW'(COLS);
    localparam logic [CW-1:0]  ONE_CW   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N*TILE_W-1:0] snap_q, snap_d;
    logic [RW-1:0]       r_q, r_d;
    logic [CLW-1:0]      c_q, c_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       empty_acc_q, empty_acc_d;
    logic [TILE_W-1:0]   max_acc_q, max_acc_d;
    logic                win_acc_q, win_acc_d;
    logic                merge_acc_q, merge_acc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                game_win_q, game_win_d;
    logic                game_lose_q, game_lose_d;
    logic                can_move_q, can_move_d;
    logic [CW-1:0]       empty_count_q, empty_count_d;
    logic [TILE_W-1:0]   max_tile_q, max_tile_d;

    logic [TILE_W-1:0]   w_tiles [N];
    logic [IW-1:0]       w_idx_right;
    logic [IW-1:0]       w_idx_down;
    logic [TILE_W-1:0]   w_cur;
    logic [TILE_W-1:0]   w_right;
    logic [TILE_W-1:0]   w_down;
    logic                w_has_right;
    logic                w_has_down;
    logic                w_last;
    logic [CW-1:0]       w_empty_next;
    logic [TILE_W-1:0]   w_max_next;
    logic                w_win_next;
    logic                w_merge_next;
    logic                w_can_move_next;
    logic                w_lose_hit;

    // Unpack the snapshot into addressable tiles.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_tiles[i] = snap_q[i*TILE_W +: TILE_W];
        end
    end

    // Current tile, its right/down neighbours and the accumulator updates.
    // Neighbour indices fall back to the current index at the board edge so
    // the read always stays in range; the has_* guards keep that from
    // counting as a self-match. The wrap from (r,COLS-1) to (r+1,0) is not
    // adjacency, which is why the right neighbour is gated on the column.
    always_comb begin
        w_has_right     = (c_q != LAST_C);
        w_has_down      = (r_q != LAST_R);
        w_last          = !w_has_right && !w_has_down;
        w_idx_right     = w_has_right ? idx_q + ONE_IDX  : idx_q;
        w_idx_down      = w_has_down  ? idx_q + COLS_IDX : idx_q;
        w_cur           = w_tiles[idx_q];
        w_right         = w_tiles[w_idx_right];
        w_down          = w_tiles[w_idx_down];
        w_empty_next    = (w_cur == '0) ? empty_acc_q + ONE_CW : empty_acc_q;
        w_max_next      = (w_cur > max_acc_q) ? w_cur : max_acc_q;
        w_win_next      = win_acc_q || (32'(w_cur) >= 32'(WIN_EXP));
        w_merge_next    = merge_acc_q
                          || (w_has_right && (w_cur == w_right))
                          || (w_has_down  && (w_cur == w_down));
        w_can_move_next = (w_empty_next != '0) || w_merge_next;
`ifdef GAME_STATUS_CONTINUE_EN
        w_lose_hit      = !w_can_move_next;
`else
        // A win already on record, or one found by this scan, suppresses lose.
        w_lose_hit      = !w_can_move_next && !game_win_q && !w_win_next;
`endif
    end

    // Next-state and output logic for the IDLE -> SCAN -> DONE sequencer.
    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        r_d           = r_q;
        c_d           = c_q;
        idx_d         = idx_q;
        empty_acc_d   = empty_acc_q;
        max_acc_d     = max_acc_q;
        win_acc_d     = win_acc_q;
        merge_acc_d   = merge_acc_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        game_win_d    = game_win_q;
        game_lose_d   = game_lose_q;
        can_move_d    = can_move_q;
        empty_count_d = empty_count_q;
        max_tile_d    = max_tile_q;

        if (bus.clear) begin
            // New game: abort any scan and wipe flags and stats.
            state_d       = S_IDLE;
            r_d           = '0;
            c_d           = '0;
            idx_d         = '0;
            empty_acc_d   = '0;
            max_acc_d     = '0;
            win_acc_d     = 1'b0;
            merge_acc_d   = 1'b0;
            busy_d        = 1'b0;
            game_win_d    = 1'b0;
            game_lose_d   = 1'b0;
            can_move_d    = 1'b0;
            empty_count_d = '0;
            max_tile_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        snap_d      = bus.board_state;
                        r_d         = '0;
                        c_d         = '0;
                        idx_d       = '0;
                        empty_acc_d = '0;
                        max_acc_d   = '0;
                        win_acc_d   = 1'b0;
                        merge_acc_d = 1'b0;
                        busy_d      = 1'b1;
                        state_d     = S_SCAN;
                    end
                end
                S_SCAN: begin
                    empty_acc_d = w_empty_next;
                    max_acc_d   = w_max_next;
                    win_acc_d   = w_win_next;
                    merge_acc_d = w_merge_next;
                    if (w_last) begin
                        // Publish results in the same edge that raises done.
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                        empty_count_d = w_empty_next;
                        max_tile_d    = w_max_next;
                        can_move_d    = w_can_move_next;
                        game_win_d    = game_win_q || w_win_next;
                        game_lose_d   = game_lose_q || w_lose_hit;
                        state_d       = S_DONE;
                    end else begin
                        idx_d = idx_q + ONE_IDX;
                        if (c_q == LAST_C) begin
                            c_d = '0;
                            r_d = r_q + ONE_R;
                        end else begin
                            c_d = c_q + ONE_C;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, snapshot, accumulators and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            snap_q        <= '0;
            r_q           <= '0;
            c_q           <= '0;
            idx_q         <= '0;
            empty_acc_q   <= '0;
            max_acc_q     <= '0;
            win_acc_q     <= 1'b0;
            merge_acc_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            game_win_q    <= 1'b0;
            game_lose_q   <= 1'b0;
            can_move_q    <= 1'b0;
            empty_count_q <= '0;
            max_tile_q    <= '0;
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            r_q           <= r_d;
            c_q           <= c_d;
            idx_q         <= idx_d;
            empty_acc_q   <= empty_acc_d;
            max_acc_q     <= max_acc_d;
            win_acc_q     <= win_acc_d;
            merge_acc_q   <= merge_acc_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            game_win_q    <= game_win_d;
            game_lose_q   <= game_lose_d;
            can_move_q    <= can_move_d;
            empty_count_q <= empty_count_d;
            max_tile_q    <= max_tile_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.game_win    = game_win_q;
    assign bus.game_lose   = game_lose_q;
    assign bus.can_move    = can_move_q;
    assign bus.empty_count = empty_count_q;
    assign bus.max_tile    = max_tile_q;

endmodule
`default_nettype wire
